ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 33 +++
 rtl/ifetch_queue.sv | 122 ++++++++++++
 tb/tb_ifetch_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: memory request side, redirect input and queue head.
// The fetch unit holds the master modport; its environment holds the slave.
interface ifetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic [2:0]  count;

  modport master (
    input  redirect, redirect_pc,
    input  imem_ack, imem_data,
    input  ins_ready,
    output imem_req, imem_addr,
    output ins_valid, ins, ins_pc,
    output count
  );

  modport slave (
    output redirect, redirect_pc,
    output imem_ack, imem_data,
    output ins_ready,
    input  imem_req, imem_addr,
    input  ins_valid, ins, ins_pc,
    input  count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single outstanding memory read feeding a small
// FIFO of {pc, instruction} pairs, with redirect flush and in-flight drop.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rstd,
  ifetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e        state_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   pc_q;
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ipc_q [DEPTH];

  logic        push;
  logic        pop;
  logic        room;
  logic        valid;
  logic [31:0] rpc;
  logic [31:0] nxt;

  assign valid = (cnt_q != '0);
  assign push  = (state_q == WAIT) & bus.imem_ack & ~bus.redirect;
  assign pop   = valid & bus.ins_ready;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  // A request is only launched while a slot is still free after this cycle
  assign room  = (cnt_d < CW'(DEPTH));
  assign rpc   = {bus.redirect_pc[31:2], 2'b00};
  assign nxt   = addr_q + 32'd4;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc_q    <= RESET_PC;
    end else begin
      if (bus.redirect) pc_q <= rpc;
      unique case (state_q)
        IDLE: begin
          if (!bus.redirect && room) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            state_q <= bus.imem_ack ? IDLE : DROP;
            req_q   <= ~bus.imem_ack;
          end else if (bus.imem_ack) begin
            pc_q <= nxt;
            if (room) begin
              addr_q <= nxt;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (bus.redirect) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wp_q] <= bus.imem_data;
      ipc_q[wp_q] <= addr_q;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.ins_valid = valid;
  assign bus.ins       = valid ? ins_q[rp_q] : '0;
  assign bus.ins_pc    = valid ? ipc_q[rp_q] : '0;
  assign bus.count     = 3'(cnt_q);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model answers on demand,
// instruction word is the fetch address xor a fixed key.
module tb_ifetch_queue;
  localparam logic [31:0] K = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic rstd = 1'b0;
  logic ack_en = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.imem_ack  = ack_en & bus.imem_req;
    bus.imem_data = bus.imem_addr ^ K;
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_data   = '0;
    bus.ins_ready   = 1'b0;
    tick();
    tick();
    chk("rst_req",   bus.imem_req,  32'd0);
    chk("rst_addr",  bus.imem_addr, 32'd0);
    chk("rst_cnt",   bus.count,     32'd0);
    chk("rst_valid", bus.ins_valid, 32'd0);
    chk("rst_ins",   bus.ins,       32'd0);
    chk("rst_pc",    bus.ins_pc,    32'd0);

    // streaming with consumer always ready
    bus.ins_ready = 1'b1;
    ack_en = 1'b1;
    rstd = 1'b1;
    tick();
    chk("first_req",  bus.imem_req,  32'd1);
    chk("first_addr", bus.imem_addr, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_pc",  bus.ins_pc, 32'(4 * i));
      chk("stream_ins", bus.ins,    32'(4 * i) ^ K);
      chk("stream_cnt", bus.count,  32'd1);
    end

    // fill with consumer stalled, then drain through pointer wrap
    rstd = 1'b0;
    bus.imem_ack = 1'b0;
    ack_en = 1'b0;
    bus.ins_ready = 1'b0;
    tick();
    ack_en = 1'b1;
    rstd = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("fill3_cnt",  bus.count,     32'd3);
    chk("fill3_req",  bus.imem_req,  32'd1);
    chk("fill3_addr", bus.imem_addr, 32'hC);
    tick();
    chk("full_cnt", bus.count,    32'd4);
    chk("full_req", bus.imem_req, 32'd0);
    tick();
    chk("hold_cnt", bus.count,    32'd4);
    chk("hold_req", bus.imem_req, 32'd0);
    bus.ins_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("drain_pc",  bus.ins_pc, 32'(4 * i));
      chk("drain_ins", bus.ins,    32'(4 * i) ^ K);
      tick();
      chk("drain_cnt", bus.count,  32'd3);
    end

    // redirect while a request is outstanding without ack
    rstd = 1'b0;
    bus.imem_ack = 1'b0;
    ack_en = 1'b0;
    bus.ins_ready = 1'b0;
    tick();
    ack_en = 1'b1;
    rstd = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_full", bus.count, 32'd4);
    ack_en = 1'b0;
    bus.ins_ready = 1'b1;
    tick();
    chk("out_req",  bus.imem_req,  32'd1);
    chk("out_addr", bus.imem_addr, 32'h10);
    bus.ins_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    tick();
    bus.redirect = 1'b0;
    chk("drop_cnt",   bus.count,     32'd0);
    chk("drop_valid", bus.ins_valid, 32'd0);
    chk("drop_req",   bus.imem_req,  32'd1);
    chk("drop_addr",  bus.imem_addr, 32'h10);
    tick();
    tick();
    chk("drop_hold", bus.imem_req,  32'd1);
    chk("drop_stab", bus.imem_addr, 32'h10);
    ack_en = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h10 ^ K;
    tick();
    chk("dack_req", bus.imem_req, 32'd0);
    chk("dack_cnt", bus.count,    32'd0);
    tick();
    chk("redir_req",  bus.imem_req,  32'd1);
    chk("redir_addr", bus.imem_addr, 32'h100);
    tick();
    chk("redir_cnt",   bus.count,     32'd1);
    chk("redir_valid", bus.ins_valid, 32'd1);
    chk("redir_pc",    bus.ins_pc,    32'h100);
    chk("redir_ins",   bus.ins,       32'h100 ^ K);

    // redirect near the top of the address space, with ack in flight
    bus.ins_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect = 1'b0;
    chk("wrap_flush", bus.count,    32'd0);
    chk("wrap_idle",  bus.imem_req, 32'd0);
    tick();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc0", bus.ins_pc, 32'hFFFF_FFF8);
    chk("wrap_cnt", bus.count,  32'd1);
    tick();
    chk("wrap_pc1", bus.ins_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2",  bus.ins_pc, 32'h0);
    chk("wrap_ins2", bus.ins,    K);

    // reset pulse in WAIT with a stale ack
    rstd = 1'b0;
    #1;
    chk("mid_req",   bus.imem_req,  32'd0);
    chk("mid_addr",  bus.imem_addr, 32'd0);
    chk("mid_cnt",   bus.count,     32'd0);
    chk("mid_valid", bus.ins_valid, 32'd0);
    chk("mid_pc",    bus.ins_pc,    32'd0);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("stale_cnt", bus.count,    32'd0);
    chk("stale_req", bus.imem_req, 32'd0);
    rstd = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cnt",  bus.count,     32'd0);
    chk("rel_req",  bus.imem_req,  32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
